// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked execute-stage ALU with a one-entry result
//                register and an iterative shift-add multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       CTRL,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             zero,
    output logic             ovf,
    output logic             branch
);

    localparam int             SHW      = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               branch_q, branch_d;
    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_ovf;
    logic               w_alu_sub;
    logic [2*WIDTH-1:0] w_acc_step;
    logic               w_accept;
    logic               w_drain;
    logic               w_start_mul;

    // Accept only when idle and the result slot is empty or draining now;
    // nothing is accepted while reset is asserted.
    assign in_ready    = reset && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_drain     = out_valid_q && out_ready;
    assign w_start_mul = MUL_EN && (CTRL == OP_MUL);

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    assign w_acc_step  = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

    assign R         = r_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign branch    = branch_q;
    assign out_valid = out_valid_q;

    // Single-cycle operation result and overflow flag.
    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        w_alu_sub = 1'b0;
        case (CTRL)
            OP_ADD: begin
                w_alu_res = A + B;
                w_alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = A - B;
                w_alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_alu_res[WIDTH-1] != A[WIDTH-1]);
                w_alu_sub = 1'b1;
            end
            OP_AND:  w_alu_res = A & B;
            OP_OR:   w_alu_res = A | B;
            OP_XOR:  w_alu_res = A ^ B;
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL:  w_alu_res = A << B[SHW-1:0];
            default: w_alu_res = '0;   // MUL with the multiplier disabled yields 0
        endcase
    end

    // Next-state logic: output slot handshake, op launch and multiply steps.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        branch_d    = branch_q;
        out_valid_d = out_valid_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;

        if (w_drain) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_start_mul) begin
                        state_d  = ST_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, A};
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        r_d         = w_alu_res;
                        ovf_d       = w_alu_ovf;
                        zero_d      = (w_alu_res == '0);
                        branch_d    = (w_alu_res == '0) && w_alu_sub;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = w_acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    r_d         = w_acc_step[WIDTH-1:0];
                    ovf_d       = |w_acc_step[2*WIDTH-1:WIDTH];
                    zero_d      = (w_acc_step[WIDTH-1:0] == '0);
                    branch_d    = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            branch_q    <= 1'b0;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            branch_q    <= branch_d;
            out_valid_q <= out_valid_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq with a transaction-level
//                reference model (result latency counter + arithmetic).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] A         = '0;
    logic [W-1:0] B         = '0;
    logic [2:0]   CTRL      = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] R;
    logic         zero;
    logic         ovf;
    logic         branch;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .CTRL      (CTRL),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .zero      (zero),
        .ovf       (ovf),
        .branch    (branch)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: visible result slot plus a pending multiply countdown
    bit           m_ov;
    logic [W-1:0] m_r;
    bit           m_ovf, m_zero, m_br;
    int           m_mul_left;
    logic [W-1:0] p_r;
    bit           p_ovf;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Architectural result of one operation, from plain integer arithmetic
    function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op,
                                   output logic [W-1:0] r, output bit v);
        longint          sa, sb, full, smax, smin;
        longint unsigned prod;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = 64'sd2147483647;
        smin = -smax - 64'sd1;
        v    = 1'b0;
        r    = '0;
        case (op)
            3'd0: begin full = sa + sb; r = full[W-1:0]; v = (full > smax) || (full < smin); end
            3'd1: begin full = sa - sb; r = full[W-1:0]; v = (full > smax) || (full < smin); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: r = a << b[4:0];
            default: begin
                prod = 64'(a) * 64'(b);
                r    = prod[W-1:0];
                v    = (prod >> W) != 0;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_ov       = 1'b0;
        m_r        = '0;
        m_ovf      = 1'b0;
        m_zero     = 1'b0;
        m_br       = 1'b0;
        m_mul_left = 0;
    endtask

    function automatic bit m_in_ready();
        return reset && (m_mul_left == 0) && (!m_ov || out_ready);
    endfunction

    // One clock: check in_ready, advance model at the edge, check outputs.
    task automatic cycle(output bit acc);
        logic [W-1:0] a, b, r;
        logic [2:0]   op;
        bit           drn, v;
        #1;
        chk("in_ready", in_ready, m_in_ready());
        acc = in_valid && m_in_ready();
        drn = m_ov && out_ready;
        a = A; b = B; op = CTRL;
        @(posedge clk);
        if (drn) m_ov = 1'b0;
        if (m_mul_left > 0) begin
            m_mul_left--;
            if (m_mul_left == 0) begin
                m_ov = 1'b1; m_r = p_r; m_ovf = p_ovf; m_zero = (p_r == 0); m_br = 1'b0;
            end
        end
        if (acc) begin
            ref_op(a, b, op, r, v);
            if (op == 3'd7) begin
                m_mul_left = W; p_r = r; p_ovf = v;
            end else begin
                m_ov = 1'b1; m_r = r; m_ovf = v; m_zero = (r == 0);
                m_br = (op == 3'd1) && (r == 0);
            end
        end
        @(negedge clk);
        chk("out_valid", out_valid, m_ov);
        chk("R", R, m_r);
        chk("zero", zero, m_zero);
        chk("ovf", ovf, m_ovf);
        chk("branch", branch, m_br);
    endtask

    task automatic drive(input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input bit ordy);
        in_valid = iv; A = a; B = b; CTRL = op; out_ready = ordy;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit           acc;
        logic [W-1:0] held;
        int           accepted, cyc;

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_R", R, 32'h0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_flags", {zero, ovf, branch}, 3'b000);
        reset = 1'b1;

        // Idle with no input
        drive(1'b0, '0, '0, 3'd0, 1'b1);
        repeat (2) cycle(acc);
        chk("idle_in_ready", in_ready, 1'b1);

        // Signed overflow on ADD; SUB equal operands drives branch
        drive(1'b1, 32'h7FFF_FFFF, 32'h1, 3'd0, 1'b1);
        cycle(acc);
        chk("add_ovf_R", R, 32'h8000_0000);
        chk("add_ovf_flag", {ovf, zero}, 2'b10);
        drive(1'b1, 32'h1234, 32'h1234, 3'd1, 1'b1);
        cycle(acc);
        chk("sub_eq_R", R, 32'h0);
        chk("sub_eq_flags", {zero, branch}, 2'b11);

        // Back-to-back single-cycle stream
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, $urandom, $urandom, 3'($urandom_range(0, 6)), 1'b1);
            cycle(acc);
            chk("stream_acc", acc, 1'b1);
        end

        // Iterative multiply: no overflow, then overflow with zero result
        drive(1'b1, 32'h0000_FFFF, 32'h0001_0001, 3'd7, 1'b1);
        cycle(acc);
        in_valid = 1'b0;
        repeat (W) cycle(acc);
        chk("mul1_R", R, 32'hFFFF_FFFF);
        chk("mul1_ovf", {out_valid, ovf}, 2'b10);
        drive(1'b1, 32'h0001_0000, 32'h0001_0000, 3'd7, 1'b1);
        cycle(acc);
        in_valid = 1'b0;
        repeat (W) cycle(acc);
        chk("mul2_flags", {out_valid, ovf, zero}, 3'b111);
        chk("mul2_R", R, 32'h0);

        // Backpressure: result held, then accept and drain on one edge
        drive(1'b1, 32'd100, 32'd23, 3'd0, 1'b0);
        cycle(acc);
        held = R;
        drive(1'b1, 32'hF0F0_0000, 32'h0FF0_1234, 3'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(acc);
            chk("bp_hold_R", R, held);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        cycle(acc);
        chk("bp_accept", acc, 1'b1);
        chk("bp_new_R", R, 32'hFF00_1234);
        in_valid = 1'b0;
        cycle(acc);

        // Reset in the middle of a multiply
        drive(1'b1, 32'd12345, 32'd678, 3'd7, 1'b1);
        cycle(acc);
        in_valid = 1'b0;
        repeat (10) cycle(acc);
        reset = 1'b0;
        #1;
        model_reset();
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_R", R, 32'h0);
        chk("mrst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (W + 3) cycle(acc);
        drive(1'b1, 32'd2, 32'd3, 3'd0, 1'b1);
        cycle(acc);
        chk("post_rst_add", R, 32'd5);
        in_valid = 1'b0;
        cycle(acc);

        // Random traffic with random backpressure
        accepted = 0;
        cyc      = 0;
        acc      = 1'b1;
        while (accepted < 1000 && cyc < 30000) begin
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                A        = $urandom;
                B        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                CTRL     = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            cycle(acc);
            if (acc) accepted++;
            cyc++;
        end
        chk("rand_accepted", 64'(accepted), 64'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
